// File: rtl/slave_sipo_rx_word_pkg.sv
// Shared definitions for the I2C slave serial receive path.
// This package holds the default word geometry and the bit-order encoding
// used by the slave PISO/SIPO blocks.
package slave_sipo_rx_word_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 4;

  // Bit-order encoding for the MSB_FIRST parameter.
  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  localparam int DEF_MSB_FIRST = int'(ORDER_MSB_FIRST);

endpackage

// File: rtl/slave_sipo_rx_word_if.sv
// Handshake/bus bundle between slave control logic and the SIPO receive word.
//   master : slave control side; drives serial bit, shift enable, frame clear,
//            data ack and overrun clear; observes the received word and status.
//   slave  : receive register side; the mirror image of master.
interface slave_sipo_rx_word_if
  import slave_sipo_rx_word_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);

  logic                  slave_serial_in;
  logic                  slave_rec_data_shift;
  logic                  slave_frame_clr;
  logic                  slave_data_ack;
  logic                  slave_ovr_clr;
  logic [DATA_WIDTH-1:0] slave_data_out;
  logic                  slave_data_valid;
  logic                  slave_word_done;
  logic                  slave_overrun;
  logic [CNT_WIDTH-1:0]  slave_bit_cnt;

  modport master (
    output slave_serial_in, slave_rec_data_shift, slave_frame_clr,
           slave_data_ack, slave_ovr_clr,
    input  slave_data_out, slave_data_valid, slave_word_done,
           slave_overrun, slave_bit_cnt
  );

  modport slave (
    input  slave_serial_in, slave_rec_data_shift, slave_frame_clr,
           slave_data_ack, slave_ovr_clr,
    output slave_data_out, slave_data_valid, slave_word_done,
           slave_overrun, slave_bit_cnt
  );

endinterface

// File: rtl/slave_bit_counter.sv
// Bit counter for the slave serial blocks.
// Counts enabled cycles from 0 to TERMINAL and wraps to 0.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   en_i   : count enable
//   clr_i  : synchronous clear, wins over en_i
//   cnt_o  : current count (registered)
//   wrap_o : high in the cycle whose enabled count step wraps TERMINAL -> 0
module slave_bit_counter #(
  parameter int CNT_WIDTH = 4,
  parameter int TERMINAL  = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 wrap_o
);

  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(TERMINAL);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == TERM) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/slave_sipo_rx_word.sv
// Serial-in/parallel-out receive word for the I2C slave data path.
// Shifts qualified SDA bits, counts them to a full word, and hands each
// completed word to slave control through a holding register with a
// valid/ack handshake. A word that completes while the holding register is
// still unconsumed is dropped and flagged in a sticky overrun bit.
//   slave_scl_sixt : oversampled slave clock, rising edge
//   slave_rst      : asynchronous active-high reset
//   bus (slave)    : serial_in, rec_data_shift, frame_clr, data_ack, ovr_clr in;
//                    data_out, data_valid, word_done, overrun, bit_cnt out
module slave_sipo_rx_word
  import slave_sipo_rx_word_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MSB_FIRST  = DEF_MSB_FIRST,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 slave_scl_sixt,
  input  logic                 slave_rst,
  slave_sipo_rx_word_if.slave  bus
);

  localparam bit SHIFT_LEFT = (MSB_FIRST == int'(ORDER_MSB_FIRST));

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  done_q;
  logic                  word_wrap;
  logic                  ovr_set;

  // Counter wraps on the shift that samples the last bit of a word; its
  // clear input already gives frame_clr priority over that shift.
  slave_bit_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .TERMINAL  (DATA_WIDTH - 1)
  ) u_bit_cnt (
    .clk_i  (slave_scl_sixt),
    .rst_i  (slave_rst),
    .en_i   (bus.slave_rec_data_shift),
    .clr_i  (bus.slave_frame_clr),
    .cnt_o  (bus.slave_bit_cnt),
    .wrap_o (word_wrap)
  );

  always_comb begin
    shift_d = shift_q;
    if (bus.slave_frame_clr) begin
      shift_d = '0;
    end else if (bus.slave_rec_data_shift) begin
      shift_d = SHIFT_LEFT ? {shift_q[DATA_WIDTH-2:0], bus.slave_serial_in}
                           : {bus.slave_serial_in, shift_q[DATA_WIDTH-1:1]};
    end
  end

  // shift_d already contains the bit sampled on this edge, so it is the
  // completion word and can be loaded on the same edge.
  assign ovr_set = word_wrap && valid_q && !bus.slave_data_ack;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (word_wrap) begin
      if (!valid_q || bus.slave_data_ack) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end
    end else if (bus.slave_data_ack) begin
      valid_d = 1'b0;
    end
  end

  // Setting wins over a simultaneous clear so a drop is never lost.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set)                ovr_d = 1'b1;
    else if (bus.slave_ovr_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge slave_scl_sixt or posedge slave_rst) begin
    if (slave_rst) begin
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      done_q  <= word_wrap;
    end
  end

  assign bus.slave_data_out   = data_q;
  assign bus.slave_data_valid = valid_q;
  assign bus.slave_word_done  = done_q;
  assign bus.slave_overrun    = ovr_q;

endmodule

// File: tb/tb_slave_sipo_rx_word.sv
module tb_slave_sipo_rx_word;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slave_sipo_rx_word_if #(.DATA_WIDTH(8),  .CNT_WIDTH(4)) if8m ();
  slave_sipo_rx_word_if #(.DATA_WIDTH(8),  .CNT_WIDTH(4)) if8l ();
  slave_sipo_rx_word_if #(.DATA_WIDTH(12), .CNT_WIDTH(4)) if12 ();

  slave_sipo_rx_word #(.DATA_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(4)) dut8m (
    .slave_scl_sixt(clk), .slave_rst(rst), .bus(if8m));
  slave_sipo_rx_word #(.DATA_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(4)) dut8l (
    .slave_scl_sixt(clk), .slave_rst(rst), .bus(if8l));
  slave_sipo_rx_word #(.DATA_WIDTH(12), .MSB_FIRST(1), .CNT_WIDTH(4)) dut12 (
    .slave_scl_sixt(clk), .slave_rst(rst), .bus(if12));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one entry per instance (0: 8b MSB-first, 1: 8b LSB-first, 2: 12b MSB-first)
  int          W  [3] = '{8, 8, 12};
  bit          MF [3] = '{1'b1, 1'b0, 1'b1};
  int          m_cnt   [3];
  bit          m_b     [3][16];
  logic [15:0] m_hold  [3];
  bit          m_valid [3];
  bit          m_done  [3];
  bit          m_ovr   [3];

  typedef struct {
    bit sh; bit b; bit clr; bit ack; bit oc;
    logic [7:0] e_data; bit e_valid; bit e_done; bit e_ovr; logic [3:0] e_cnt;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Word value from the bits received in arrival order.
  function automatic logic [15:0] assemble(int k);
    logic [15:0] w;
    w = '0;
    for (int j = 0; j < W[k]; j++)
      if (m_b[k][j]) begin
        if (MF[k]) w[W[k]-1-j] = 1'b1;
        else       w[j] = 1'b1;
      end
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_hold[k] = '0; m_valid[k] = 0; m_done[k] = 0; m_ovr[k] = 0;
    end
  endtask

  task automatic model_step(bit sh, bit b, bit clr, bit ack, bit oc);
    for (int k = 0; k < 3; k++) begin
      bit done_n;
      bit ovr_set;
      done_n = 0;
      ovr_set = 0;
      if (clr) m_cnt[k] = 0;
      else if (sh) begin
        m_b[k][m_cnt[k]] = b;
        if (m_cnt[k] == W[k] - 1) begin
          m_cnt[k] = 0;
          done_n = 1;
        end else m_cnt[k]++;
      end
      if (done_n) begin
        if (!m_valid[k] || ack) begin
          m_hold[k] = assemble(k);
          m_valid[k] = 1;
        end else ovr_set = 1;
      end else if (ack) m_valid[k] = 0;
      if (ovr_set) m_ovr[k] = 1;
      else if (oc) m_ovr[k] = 0;
      m_done[k] = done_n;
    end
  endtask

  task automatic check_all(string tag);
    logic [15:0] ad [3];
    logic        av [3], adn [3], ao [3];
    logic [3:0]  ac [3];
    ad[0] = 16'(if8m.slave_data_out); ad[1] = 16'(if8l.slave_data_out); ad[2] = 16'(if12.slave_data_out);
    av[0] = if8m.slave_data_valid;    av[1] = if8l.slave_data_valid;    av[2] = if12.slave_data_valid;
    adn[0] = if8m.slave_word_done;    adn[1] = if8l.slave_word_done;    adn[2] = if12.slave_word_done;
    ao[0] = if8m.slave_overrun;       ao[1] = if8l.slave_overrun;       ao[2] = if12.slave_overrun;
    ac[0] = if8m.slave_bit_cnt;       ac[1] = if8l.slave_bit_cnt;       ac[2] = if12.slave_bit_cnt;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s i%0d data", tag, k),  32'(ad[k]),  32'(m_hold[k]));
      chk($sformatf("%s i%0d valid", tag, k), 32'(av[k]),  32'(m_valid[k]));
      chk($sformatf("%s i%0d done", tag, k),  32'(adn[k]), 32'(m_done[k]));
      chk($sformatf("%s i%0d ovr", tag, k),   32'(ao[k]),  32'(m_ovr[k]));
      chk($sformatf("%s i%0d cnt", tag, k),   32'(ac[k]),  32'(m_cnt[k]));
    end
  endtask

  task automatic drive(bit sh, bit b, bit clr, bit ack, bit oc);
    if8m.slave_rec_data_shift = sh; if8m.slave_serial_in = b; if8m.slave_frame_clr = clr;
    if8m.slave_data_ack = ack; if8m.slave_ovr_clr = oc;
    if8l.slave_rec_data_shift = sh; if8l.slave_serial_in = b; if8l.slave_frame_clr = clr;
    if8l.slave_data_ack = ack; if8l.slave_ovr_clr = oc;
    if12.slave_rec_data_shift = sh; if12.slave_serial_in = b; if12.slave_frame_clr = clr;
    if12.slave_data_ack = ack; if12.slave_ovr_clr = oc;
  endtask

  // Apply one cycle of inputs, clock it, and compare all instances to the model.
  task automatic step(string tag, bit sh, bit b, bit clr, bit ack, bit oc);
    drive(sh, b, clr, ack, oc);
    @(posedge clk);
    model_step(sh, b, clr, ack, oc);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(string tag, logic [15:0] w, int n, bit ack_last);
    for (int j = n - 1; j >= 0; j--)
      step(tag, 1'b1, w[j], 1'b0, ack_last && (j == 0), 1'b0);
  endtask

  task automatic do_reset(string tag);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    model_reset();
    check_all({tag, " rst"});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    #1;
    do_reset("init");

    // A5 MSB-first: explicit expectations for the 8-bit MSB-first instance
    tbl[0]  = '{1,1,0,0,0, 8'h00,0,0,0, 4'd1};
    tbl[1]  = '{1,0,0,0,0, 8'h00,0,0,0, 4'd2};
    tbl[2]  = '{1,1,0,0,0, 8'h00,0,0,0, 4'd3};
    tbl[3]  = '{1,0,0,0,0, 8'h00,0,0,0, 4'd4};
    tbl[4]  = '{1,0,0,0,0, 8'h00,0,0,0, 4'd5};
    tbl[5]  = '{1,1,0,0,0, 8'h00,0,0,0, 4'd6};
    tbl[6]  = '{1,0,0,0,0, 8'h00,0,0,0, 4'd7};
    tbl[7]  = '{1,1,0,0,0, 8'hA5,1,1,0, 4'd0};
    tbl[8]  = '{0,0,0,0,0, 8'hA5,1,0,0, 4'd0};
    tbl[9]  = '{0,0,0,1,0, 8'hA5,0,0,0, 4'd0};
    tbl[10] = '{0,0,0,1,0, 8'hA5,0,0,0, 4'd0};
    for (int i = 0; i < 11; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].sh, tbl[i].b, tbl[i].clr, tbl[i].ack, tbl[i].oc);
      chk($sformatf("tbl%0d data", i),  32'(if8m.slave_data_out),   32'(tbl[i].e_data));
      chk($sformatf("tbl%0d valid", i), 32'(if8m.slave_data_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d done", i),  32'(if8m.slave_word_done),  32'(tbl[i].e_done));
      chk($sformatf("tbl%0d ovr", i),   32'(if8m.slave_overrun),    32'(tbl[i].e_ovr));
      chk($sformatf("tbl%0d cnt", i),   32'(if8m.slave_bit_cnt),    32'(tbl[i].e_cnt));
    end

    // Bit order: stream 1,0,0,0,0,0,0,0
    do_reset("order");
    send_word("order", 16'h0080, 8, 1'b0);
    chk("order msb data", 32'(if8m.slave_data_out), 32'h80);
    chk("order lsb data", 32'(if8l.slave_data_out), 32'h01);

    // Overrun: second word dropped while first unconsumed
    do_reset("ovr");
    send_word("ovr", 16'h003C, 8, 1'b0);
    send_word("ovr", 16'h00C3, 8, 1'b0);
    chk("ovr data kept", 32'(if8m.slave_data_out), 32'h3C);
    chk("ovr flag", 32'(if8m.slave_overrun), 32'h1);
    chk("ovr done pulse", 32'(if8m.slave_word_done), 32'h1);
    step("ovr ack", 0, 0, 0, 1, 0);
    chk("ovr ack valid", 32'(if8m.slave_data_valid), 32'h0);
    chk("ovr sticky", 32'(if8m.slave_overrun), 32'h1);
    step("ovr clr", 0, 0, 0, 0, 1);
    chk("ovr cleared", 32'(if8m.slave_overrun), 32'h0);

    // Ack on the completing edge reloads without overrun
    do_reset("ackc");
    send_word("ackc", 16'h0011, 8, 1'b0);
    send_word("ackc", 16'h0022, 8, 1'b1);
    chk("ackc data", 32'(if8m.slave_data_out), 32'h22);
    chk("ackc valid", 32'(if8m.slave_data_valid), 32'h1);
    chk("ackc ovr", 32'(if8m.slave_overrun), 32'h0);

    // Frame abort with simultaneous shift
    do_reset("abort");
    for (int i = 0; i < 5; i++) step("abort", 1, 1'b1, 0, 0, 0);
    step("abort clr", 1, 1'b1, 1, 0, 0);
    chk("abort cnt", 32'(if8m.slave_bit_cnt), 32'h0);
    chk("abort no done", 32'(if8m.slave_word_done), 32'h0);
    send_word("abort", 16'h005A, 8, 1'b0);
    chk("abort data", 32'(if8m.slave_data_out), 32'h5A);

    // 12-bit word, then async reset mid-word
    do_reset("w12");
    send_word("w12", 16'h0F0F, 12, 1'b0);
    chk("w12 data", 32'(if12.slave_data_out), 32'hF0F);
    chk("w12 valid", 32'(if12.slave_data_valid), 32'h1);
    for (int i = 0; i < 6; i++) step("w12 part", 1, 1'(i & 1), 0, 0, 0);
    chk("w12 part cnt", 32'(if12.slave_bit_cnt), 32'h6);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst data", 32'(if12.slave_data_out), 32'h0);
    chk("arst valid", 32'(if12.slave_data_valid), 32'h0);
    chk("arst cnt", 32'(if12.slave_bit_cnt), 32'h0);
    check_all("arst");
    #1;
    rst = 1'b0;
    send_word("w12 post", 16'h0ABC, 12, 1'b0);
    chk("w12 post data", 32'(if12.slave_data_out), 32'hABC);

    // Randomized traffic against the model
    do_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      bit sh, b, clr, ack, oc;
      sh  = ($urandom_range(0, 9) < 7);
      b   = 1'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      ack = ($urandom_range(0, 3) == 0);
      oc  = ($urandom_range(0, 9) == 0);
      step("rnd", sh, b, clr, ack, oc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slave_sipo_rx_word.md
Name: slave_sipo_rx_word

Overview:
- Parametrised serial-in/parallel-out receive register for the I2C slave data path.
- Shifts qualified SDA bits on the slave oversampled clock and counts bits to a full word.
- Transfers each completed word into a holding register with a valid/ack handshake toward slave control logic.
- Adds bit-order selection, a frame-abort clear, and sticky overrun detection.

Parameters:
- DATA_WIDTH, 8, bits per received word (>=2).
- MSB_FIRST, 1, 1 = left shift with serial bit entering bit 0 (I2C order); 0 = right shift with serial bit entering bit DATA_WIDTH-1.
- CNT_WIDTH, 4, bit-counter width; must satisfy 2**CNT_WIDTH >= DATA_WIDTH.

Ports:
- slave_scl_sixt  input  1  block clock; all state updates on the rising edge.
- slave_rst  input  1  asynchronous, active-high reset.
- slave_serial_in  input  1  sampled SDA bit.
- slave_rec_data_shift  input  1  shift enable; samples slave_serial_in on this edge.
- slave_frame_clr  input  1  START/repeated-START/STOP seen; discards the partial word.
- slave_data_ack  input  1  consumer has taken slave_data_out.
- slave_ovr_clr  input  1  clears the sticky overrun flag.
- slave_data_out  output  DATA_WIDTH  holding register (last completed word).
- slave_data_valid  output  1  holding register contains an unconsumed word.
- slave_word_done  output  1  one-cycle pulse when a word completes.
- slave_overrun  output  1  sticky; a completed word was dropped.
- slave_bit_cnt  output  CNT_WIDTH  bits received in the current word (0..DATA_WIDTH-1).

Behaviour:
- Clocking and reset:
  - One clock, slave_scl_sixt; reset is asynchronous and active-high on slave_rst.
  - On reset: shift register, slave_bit_cnt, slave_data_out, slave_data_valid, slave_word_done and slave_overrun all go to 0.
- Shift step (slave_rec_data_shift=1, slave_frame_clr=0):
  - MSB_FIRST=1: shift_reg <= {shift_reg[W-2:0], serial_in}.
  - MSB_FIRST=0: shift_reg <= {serial_in, shift_reg[W-1:1]}.
  - With slave_rec_data_shift=0 the shift register and counter hold.
- Word completion, when a shift occurs with slave_bit_cnt==DATA_WIDTH-1:
  - Counter wraps to 0.
  - slave_word_done=1 for exactly the next cycle.
  - The assembled word, including the current bit, is the completion word.
- Latency: the completion word appears on slave_data_out with slave_data_valid=1 on the same edge that samples the last bit.
- Holding register and handshake:
  - If valid=0, or valid=1 with slave_data_ack=1 in the same cycle: load the completion word, valid=1, no overrun.
  - If valid=1 and ack=0: slave_data_out is unchanged, the new word is dropped, and slave_overrun is set to 1. word_done still pulses.
  - ack with no completion: valid goes to 0 next cycle and data_out holds its value.
  - ack while valid=0 is ignored.
- slave_frame_clr:
  - Clears the shift register and counter to 0 and has priority over a simultaneous shift; that shift's bit is discarded and no completion occurs.
  - Does not touch slave_data_out, slave_data_valid or slave_overrun.
- Overrun flag:
  - Cleared only by slave_ovr_clr or reset.
  - Set has priority over a simultaneous clear.
- Reset mid-word: partial word lost; the next word starts from bit 0.
- slave_word_done is registered; no output is combinational from inputs.

Decomposition:
- Shared include slave_defs.vh: default DATA_WIDTH (8), default CNT_WIDTH (4), MSB_FIRST encoding constants; shared with the existing slave PISO/SIPO blocks.
- One natural sub-module, slave_bit_counter, parametrised by CNT_WIDTH and a terminal value. It provides enable, synchronous clear and async reset, and outputs the count plus a wrap strobe.
- The shift register, holding register and overrun logic stay in the top module.

Test Plan:
- Reset then MSB_FIRST=1: shift 1,0,1,0,0,1,0,1 → data_out=8'hA5, valid=1, word_done high one cycle, bit_cnt back to 0.
- MSB_FIRST=0: shift the same sequence → data_out=8'hA5 bit-reversed, i.e. 8'hA5 LSB-first sent as 1,0,1,0,0,1,0,1 → 8'hA5 reversed = 8'hA5? Use 8'h01 sent as 1,0,0,0,0,0,0,0 → 8'h01; with MSB_FIRST=1 the same stream → 8'h80.
- Overrun: receive 8'h3C (no ack), then 8'hC3 → data_out stays 8'h3C, overrun=1. Ack → valid=0. ovr_clr → overrun=0.
- Simultaneous ack and completion: valid=1 with 8'h11, ack asserted on the last-bit edge of 8'h22 → data_out=8'h22, valid=1, overrun=0.
- Frame abort: 5 bits shifted, then frame_clr together with a shift → bit_cnt=0. The next 8 bits 8'h5A give data_out=8'h5A with no stale bits.
- DATA_WIDTH=12, CNT_WIDTH=4: shift 12'hF0F MSB-first → data_out=12'hF0F after 12 shifts. Async reset asserted mid-word (after 6 bits) → all outputs 0 immediately, without waiting for a clock edge.
